// File: rtl/phase5_lock_checker.sv
// Receive-side checker for the phase-5 time-lock stream (01 -> 10 -> 11 with bounded runs).
// Reports a sticky pass or a sticky fail with a cause code to the vault sequencer.
module phase5_lock_checker #(
  parameter int HOLD_MIN     = 5,
  parameter int HOLD_MAX     = 7,
  parameter int IDLE_TIMEOUT = 32,
  parameter int CNT_W        = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       arm,
  input  logic [1:0] lock_in,
  output logic       unlock_ok,
  output logic       lock_fail,
  output logic [2:0] fail_code,
  output logic [1:0] stage,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT01 = 3'd1,
    ST_S01    = 3'd2,
    ST_S10    = 3'd3,
    ST_S11    = 3'd4,
    ST_PASS   = 3'd5,
    ST_FAIL   = 3'd6
  } state_t;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ORDER   = 3'd1;
  localparam logic [2:0] FC_TIMEOUT = 3'd2;
  localparam logic [2:0] FC_SHORT   = 3'd3;
  localparam logic [2:0] FC_LONG    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HOLD_MIN_C  = CNT_W'(HOLD_MIN);
  localparam logic [CNT_W-1:0] HOLD_MAX_C  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(IDLE_TIMEOUT);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [2:0]       fcode_r, fcode_s;
  logic             unlock_ok_s, lock_fail_s, busy_s;
  logic [2:0]       fail_code_s;
  logic [1:0]       stage_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  assign cnt_inc_s = sat_inc(cnt_r);

  // Next-state and run-length counter; arm outranks every state-specific rule.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    fcode_s = fcode_r;
    if (arm) begin
      state_s = ST_WAIT01;
      cnt_s   = '0;
      fcode_s = FC_NONE;
    end else begin
      case (state_r)
        ST_WAIT01: begin
          case (lock_in)
            2'b00: begin
              if (cnt_inc_s == TIMEOUT_C) begin
                state_s = ST_FAIL;
                cnt_s   = '0;
                fcode_s = FC_TIMEOUT;
              end else begin
                cnt_s = cnt_inc_s;
              end
            end
            2'b01: begin
              state_s = ST_S01;
              cnt_s   = CNT_ONE;
            end
            default: begin
              state_s = ST_FAIL;
              cnt_s   = '0;
              fcode_s = FC_ORDER;
            end
          endcase
        end
        ST_S01, ST_S10: begin
          // Same rules for both middle codes: hold the code, or step to its successor.
          if (lock_in == ((state_r == ST_S01) ? 2'b01 : 2'b10)) begin
            if (cnt_inc_s == HOLD_MAX_C) begin
              state_s = ST_FAIL;
              cnt_s   = '0;
              fcode_s = FC_LONG;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end else if (lock_in == ((state_r == ST_S01) ? 2'b10 : 2'b11)) begin
            if (cnt_r >= HOLD_MIN_C) begin
              state_s = (state_r == ST_S01) ? ST_S10 : ST_S11;
              cnt_s   = CNT_ONE;
            end else begin
              state_s = ST_FAIL;
              cnt_s   = '0;
              fcode_s = FC_SHORT;
            end
          end else begin
            state_s = ST_FAIL;
            cnt_s   = '0;
            fcode_s = FC_ORDER;
          end
        end
        ST_S11: begin
          if (lock_in == 2'b11) begin
            if (cnt_inc_s == HOLD_MIN_C) begin
              state_s = ST_PASS;
              cnt_s   = '0;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end else begin
            state_s = ST_FAIL;
            cnt_s   = '0;
            fcode_s = FC_ORDER;
          end
        end
        ST_IDLE, ST_PASS, ST_FAIL: begin
          state_s = state_r;
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = '0;
          fcode_s = FC_NONE;
        end
      endcase
    end
  end

  // Moore decode of the upcoming state so outputs are valid from the entering edge.
  always_comb begin
    unlock_ok_s = 1'b0;
    lock_fail_s = 1'b0;
    fail_code_s = FC_NONE;
    stage_s     = 2'd0;
    busy_s      = 1'b0;
    case (state_s)
      ST_WAIT01: busy_s = 1'b1;
      ST_S01: begin
        stage_s = 2'd1;
        busy_s  = 1'b1;
      end
      ST_S10: begin
        stage_s = 2'd2;
        busy_s  = 1'b1;
      end
      ST_S11: begin
        stage_s = 2'd3;
        busy_s  = 1'b1;
      end
      ST_PASS: begin
        unlock_ok_s = 1'b1;
        stage_s     = 2'd3;
      end
      ST_FAIL: begin
        lock_fail_s = 1'b1;
        fail_code_s = fcode_s;
      end
      default: busy_s = 1'b0;
    endcase
  end

  // State, counter, cause and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      fcode_r   <= FC_NONE;
      unlock_ok <= 1'b0;
      lock_fail <= 1'b0;
      fail_code <= FC_NONE;
      stage     <= 2'd0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      fcode_r   <= fcode_s;
      unlock_ok <= unlock_ok_s;
      lock_fail <= lock_fail_s;
      fail_code <= fail_code_s;
      stage     <= stage_s;
      busy      <= busy_s;
    end
  end

endmodule

// File: tb/tb_phase5_lock_checker.sv
// Directed self-checking bench for phase5_lock_checker: nominal, boundary runs,
// every failure cause, reset mid-check and re-arm from PASS.
module tb_phase5_lock_checker;

  logic       clk;
  logic       reset_n;
  logic       arm;
  logic [1:0] lock_in;
  logic       unlock_ok;
  logic       lock_fail;
  logic [2:0] fail_code;
  logic [1:0] stage;
  logic       busy;

  int n_tests;
  int n_fail;

  phase5_lock_checker dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .arm       (arm),
    .lock_in   (lock_in),
    .unlock_ok (unlock_ok),
    .lock_fail (lock_fail),
    .fail_code (fail_code),
    .stage     (stage),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks all five outputs at once against expected values.
  task automatic check_out(input string tag, input logic ok, input logic fl,
                           input logic [2:0] fc, input logic [1:0] st, input logic bz);
    check_eq({tag, ".unlock_ok"}, 32'(unlock_ok), 32'(ok));
    check_eq({tag, ".lock_fail"}, 32'(lock_fail), 32'(fl));
    check_eq({tag, ".fail_code"}, 32'(fail_code), 32'(fc));
    check_eq({tag, ".stage"},     32'(stage),     32'(st));
    check_eq({tag, ".busy"},      32'(busy),      32'(bz));
  endtask

  task automatic step(input logic a, input logic [1:0] code);
    arm     = a;
    lock_in = code;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic send(input logic [1:0] code, input int n);
    for (int i = 0; i < n; i++) step(1'b0, code);
  endtask

  task automatic do_arm();
    step(1'b1, 2'b00);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    arm     = 1'b0;
    lock_in = 2'b00;

    // Reset, with arm asserted to show reset wins
    step(1'b1, 2'b01);
    step(1'b0, 2'b00);
    check_out("reset", 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
    reset_n = 1'b1;
    send(2'b01, 3);
    check_out("idle_ignores", 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);

    // Nominal stream
    do_arm();
    check_out("armed", 1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
    send(2'b00, 2);
    check_out("wait00", 1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
    send(2'b01, 1);
    check_eq("nom.enter01", 32'(stage), 32'd1);
    send(2'b01, 5);
    send(2'b10, 1);
    check_eq("nom.enter10", 32'(stage), 32'd2);
    send(2'b10, 5);
    send(2'b11, 4);
    check_out("nom.11x4", 1'b0, 1'b0, 3'd0, 2'd3, 1'b1);
    send(2'b11, 1);
    check_out("nom.pass", 1'b1, 1'b0, 3'd0, 2'd3, 1'b0);
    send(2'b00, 3);
    check_out("pass.hold", 1'b1, 1'b0, 3'd0, 2'd3, 1'b0);

    // Re-arm from PASS, then nominal again
    do_arm();
    check_out("rearm", 1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
    send(2'b00, 2);
    send(2'b01, 6);
    send(2'b10, 6);
    send(2'b11, 5);
    check_out("rearm.pass", 1'b1, 1'b0, 3'd0, 2'd3, 1'b0);

    // Minimum accepted runs: 5 each
    do_arm();
    send(2'b01, 5);
    send(2'b10, 5);
    send(2'b11, 5);
    check_out("min5.pass", 1'b1, 1'b0, 3'd0, 2'd3, 1'b0);

    // Short: 01x4 then 10
    do_arm();
    send(2'b01, 4);
    send(2'b10, 1);
    check_out("short", 1'b0, 1'b1, 3'd3, 2'd0, 1'b0);
    send(2'b01, 3);
    check_out("fail.hold", 1'b0, 1'b1, 3'd3, 2'd0, 1'b0);

    // lock_in during the arm cycle is ignored, so only four 01 samples count
    step(1'b1, 2'b01);
    send(2'b01, 4);
    send(2'b10, 1);
    check_eq("arm_ignores.code", 32'(fail_code), 32'd3);

    // Long: 6 samples still fine, 7th fails
    do_arm();
    send(2'b01, 6);
    check_out("long.6", 1'b0, 1'b0, 3'd0, 2'd1, 1'b1);
    send(2'b01, 1);
    check_out("long.7", 1'b0, 1'b1, 3'd4, 2'd0, 1'b0);

    // Long in 10 stage
    do_arm();
    send(2'b01, 5);
    send(2'b10, 7);
    check_eq("long10.code", 32'(fail_code), 32'd4);

    // Timeout: 31 idle samples tolerated, 32nd fails
    do_arm();
    send(2'b00, 31);
    check_out("tmo.31", 1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
    send(2'b00, 1);
    check_out("tmo.32", 1'b0, 1'b1, 3'd2, 2'd0, 1'b0);

    // Order: 01x6 then 11
    do_arm();
    send(2'b01, 6);
    send(2'b11, 1);
    check_out("order.01_11", 1'b0, 1'b1, 3'd1, 2'd0, 1'b0);

    // Order: 10 before any 01
    do_arm();
    send(2'b10, 1);
    check_eq("order.wait10", 32'(fail_code), 32'd1);

    // Order: 11 broken by 00
    do_arm();
    send(2'b01, 6);
    send(2'b10, 6);
    send(2'b11, 2);
    send(2'b00, 1);
    check_eq("order.s11", 32'(fail_code), 32'd1);

    // Reset mid-check while in S10
    do_arm();
    send(2'b01, 6);
    send(2'b10, 2);
    check_eq("mid.s10", 32'(stage), 32'd2);
    reset_n = 1'b0;
    step(1'b0, 2'b10);
    reset_n = 1'b1;
    check_out("mid.reset", 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
    send(2'b01, 2);
    send(2'b10, 2);
    check_out("mid.idle", 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
    do_arm();
    check_eq("mid.arm_busy", 32'(busy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
